bcd2bin_shift: RTL and testbench

//  Sequential 8-digit BCD to 27-bit binary converter (reverse double-dabble:

---
 rtl/bcd2bin_shift.sv | 130 +++++++++++++
 tb/tb_bcd2bin_shift.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_shift.sv
// bcd2bin_shift: sequential 8-digit BCD to 27-bit binary converter.
// Reverse double-dabble: shift {BCD,BIN} right once per step, then subtract 3
// from every BCD digit that reads 8 or more. 27 steps plus one finish cycle.
module bcd2bin_shift #(
    parameter int C_WO_LATCH = 0
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic        EN_CK_i,
    input  logic [31:0] DAT_i,
    input  logic        REQ_i,
    output logic [26:0] QQ_o,
    output logic        DONE_o,
    output logic        BUSY_o,
    output logic        ERR_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] bcd_sr, bcd_nx;
    logic [26:0] bin_sr, bin_nx;
    logic [4:0]  ctr, ctr_nx;
    logic        err_sr, err_nx;
    logic        busy_q;
    logic [31:0] bcd_shr, bcd_cor;
    logic        in_err;

    // Flag any input digit above 9 at request time.
    always_comb begin
        in_err = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (DAT_i[4*i +: 4] > 4'd9) in_err = 1'b1;
        end
    end

    // One conversion step: shift right, then correct digits >= 8 by -3.
    always_comb begin
        bcd_shr = {1'b0, bcd_sr[31:1]};
        bcd_cor = bcd_shr;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bcd_shr[4*i +: 4] >= 4'd8) bcd_cor[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
        end
    end

    // Next-state logic; a request restarts the job from any state.
    always_comb begin
        state_nx = state;
        bcd_nx   = bcd_sr;
        bin_nx   = bin_sr;
        ctr_nx   = ctr;
        err_nx   = err_sr;
        if (REQ_i) begin
            state_nx = ST_SHIFT;
            bcd_nx   = DAT_i;
            bin_nx   = '0;
            ctr_nx   = '0;
            err_nx   = in_err;
        end else begin
            case (state)
                ST_SHIFT: begin
                    bcd_nx = bcd_cor;
                    bin_nx = {bcd_sr[0], bin_sr[26:1]};
                    ctr_nx = ctr + 5'd1;
                    if (ctr == 5'd26) state_nx = ST_FIN;
                end
                ST_FIN:  state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Working registers, frozen while the clock enable is low.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state  <= ST_IDLE;
            bcd_sr <= '0;
            bin_sr <= '0;
            ctr    <= '0;
            err_sr <= 1'b0;
            busy_q <= 1'b0;
        end else if (EN_CK_i) begin
            state  <= state_nx;
            bcd_sr <= bcd_nx;
            bin_sr <= bin_nx;
            ctr    <= ctr_nx;
            err_sr <= err_nx;
            busy_q <= (state_nx != ST_IDLE);
        end
    end

    assign BUSY_o = busy_q;

    generate
        if (C_WO_LATCH == 0) begin : g_latch
            logic [26:0] qq_q;
            logic        done_q;
            logic        err_q;

            // Capture the result on the finish edge; FIN is latched even when
            // a new request loads at the same edge.
            always_ff @(posedge CK_i or negedge XARST_i) begin
                if (!XARST_i) begin
                    qq_q   <= '0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end else if (EN_CK_i) begin
                    done_q <= (state == ST_FIN);
                    if (state == ST_FIN) begin
                        qq_q  <= bin_sr;
                        err_q <= err_sr;
                    end
                end
            end

            assign QQ_o   = qq_q;
            assign DONE_o = done_q;
            assign ERR_o  = err_q;
        end else begin : g_nolatch
            assign QQ_o   = bin_sr;
            assign DONE_o = (state == ST_FIN);
            assign ERR_o  = err_sr;
        end
    endgenerate

endmodule

// File: tb/tb_bcd2bin_shift.sv
// tb_bcd2bin_shift: random and directed checks of both output modes against
// a decimal-arithmetic reference model.
module tb_bcd2bin_shift;

    logic        CK_i = 1'b0;
    logic        XARST_i;
    logic        EN_CK_i;
    logic [31:0] DAT_i;
    logic        REQ_i;
    logic [26:0] qq0, qq1;
    logic        done0, done1, busy0, busy1, err0, err1;

    int n_chk = 0;
    int n_err = 0;

    bcd2bin_shift #(.C_WO_LATCH(0)) u_dut0 (
        .CK_i(CK_i), .XARST_i(XARST_i), .EN_CK_i(EN_CK_i), .DAT_i(DAT_i), .REQ_i(REQ_i),
        .QQ_o(qq0), .DONE_o(done0), .BUSY_o(busy0), .ERR_o(err0)
    );

    bcd2bin_shift #(.C_WO_LATCH(1)) u_dut1 (
        .CK_i(CK_i), .XARST_i(XARST_i), .EN_CK_i(EN_CK_i), .DAT_i(DAT_i), .REQ_i(REQ_i),
        .QQ_o(qq1), .DONE_o(done1), .BUSY_o(busy1), .ERR_o(err1)
    );

    always #5 CK_i = ~CK_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Decimal value of a BCD word.
    function automatic logic [26:0] bcd_val(input logic [31:0] dat);
        int v = 0;
        int p = 1;
        for (int i = 0; i < 8; i++) begin
            v += int'((dat >> (4 * i)) & 32'hF) * p;
            p *= 10;
        end
        return v[26:0];
    endfunction

    function automatic logic bcd_bad(input logic [31:0] dat);
        logic bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (((dat >> (4 * i)) & 32'hF) > 32'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] w = '0;
        for (int i = 0; i < 8; i++) w = (w << 4) | 32'($urandom_range(0, 9));
        return w;
    endfunction

    task automatic tick();
        @(posedge CK_i);
        #1;
    endtask

    // One full conversion; optional enable toggling between enabled edges.
    task automatic do_conv(input logic [31:0] dat, input bit tog, input bit chk_qq);
        int          early;
        int          busy_lo;
        logic [26:0] exp_q;
        logic        exp_e;
        exp_q   = bcd_val(dat);
        exp_e   = bcd_bad(dat);
        early   = 0;
        busy_lo = 0;
        DAT_i   = dat;
        REQ_i   = 1'b1;
        EN_CK_i = 1'b1;
        tick();
        REQ_i = 1'b0;
        check("busy_rise", 32'(busy0), 32'd1);
        for (int n = 1; n <= 28; n++) begin
            if (tog) begin
                EN_CK_i = 1'b0;
                tick();
                EN_CK_i = 1'b1;
            end
            tick();
            if (n < 28) begin
                if (done0) early++;
                if (!busy0) busy_lo++;
            end
            if (n == 27) begin
                check("nolatch_done", 32'(done1), 32'd1);
                check("nolatch_err", 32'(err1), 32'(exp_e));
                if (chk_qq) check("nolatch_qq", 32'(qq1), 32'(exp_q));
            end
        end
        check("early_done", 32'(early), 32'd0);
        check("busy_hold", 32'(busy_lo), 32'd0);
        check("done", 32'(done0), 32'd1);
        check("busy_fall", 32'(busy0), 32'd0);
        check("err", 32'(err0), 32'(exp_e));
        if (chk_qq) check("qq", 32'(qq0), 32'(exp_q));
        check("nolatch_done_fall", 32'(done1), 32'd0);
        EN_CK_i = 1'b0;
        tick();
        check("done_stretch", 32'(done0), 32'd1);
        EN_CK_i = 1'b1;
        tick();
        check("done_drop", 32'(done0), 32'd0);
    endtask

    initial begin
        logic [31:0] dat;
        logic [26:0] exp_q;
        int          spur;

        XARST_i = 1'b0;
        EN_CK_i = 1'b1;
        REQ_i   = 1'b0;
        DAT_i   = '0;
        #3;
        check("rst_qq", 32'(qq0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_qq1", 32'(qq1), 32'd0);
        #9;
        XARST_i = 1'b1;
        tick();

        do_conv(32'h12345678, 1'b0, 1'b1);
        check("qq_12345678", 32'(qq0), 32'h00BC614E);
        do_conv(32'h99999999, 1'b0, 1'b1);
        check("qq_max", 32'(qq0), 32'h05F5E0FF);
        do_conv(32'h00000000, 1'b0, 1'b1);
        do_conv(32'h0000000A, 1'b0, 1'b0);
        check("err_set", 32'(err0), 32'd1);
        do_conv(32'h00000001, 1'b0, 1'b1);
        check("err_clear", 32'(err0), 32'd0);

        // Restart: second request 10 clocks after the first.
        DAT_i = 32'h00000001;
        REQ_i = 1'b1;
        tick();
        REQ_i = 1'b0;
        spur  = 0;
        repeat (9) begin
            tick();
            if (done0 || done1) spur++;
        end
        check("restart_nodone", 32'(spur), 32'd0);
        do_conv(32'h00000042, 1'b0, 1'b1);
        check("restart_qq", 32'(qq0), 32'd42);

        do_conv(32'h00065536, 1'b1, 1'b1);
        check("en_toggle_qq", 32'(qq0), 32'd65536);

        // Back-to-back random words; each new request lands on the FIN edge.
        dat   = rand_bcd();
        exp_q = bcd_val(dat);
        DAT_i = dat;
        REQ_i = 1'b1;
        tick();
        REQ_i = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            repeat (27) tick();
            check("rnd_nolatch_qq", 32'(qq1), 32'(exp_q));
            check("rnd_nolatch_done", 32'(done1), 32'd1);
            dat   = rand_bcd();
            DAT_i = dat;
            REQ_i = (k < 1499);
            tick();
            REQ_i = 1'b0;
            check("rnd_qq", 32'(qq0), 32'(exp_q));
            check("rnd_done", 32'(done0), 32'd1);
            check("rnd_busy", 32'(busy0), (k < 1499) ? 32'd1 : 32'd0);
            exp_q = bcd_val(dat);
        end
        tick();

        // Asynchronous reset in the middle of a conversion.
        DAT_i = 32'h87654321;
        REQ_i = 1'b1;
        tick();
        REQ_i = 1'b0;
        repeat (10) tick();
        #2;
        XARST_i = 1'b0;
        #1;
        check("arst_qq", 32'(qq0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_err", 32'(err0), 32'd0);
        check("arst_qq1", 32'(qq1), 32'd0);
        #1;
        XARST_i = 1'b1;
        spur = 0;
        repeat (40) begin
            tick();
            if (done0 || done1 || busy0) spur++;
        end
        check("arst_nodone", 32'(spur), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
